// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-code, state and class definitions
// for the hardwired control sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_SHR = 5'b00101;
    localparam logic [4:0] ALU_SHL = 5'b00110;
    localparam logic [4:0] ALU_ROR = 5'b00111;
    localparam logic [4:0] ALU_AND = 5'b01000;
    localparam logic [4:0] ALU_OR  = 5'b01010;
    localparam logic [4:0] ALU_ROL = 5'b01011;
    localparam logic [4:0] ALU_MUL = 5'b01110;
    localparam logic [4:0] ALU_DIV = 5'b01111;
    localparam logic [4:0] ALU_NEG = 5'b10000;
    localparam logic [4:0] ALU_NOT = 5'b10001;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2,
        S_T3, S_T4, S_T5, S_T6, S_HALTED
    } state_e;

    typedef enum logic [2:0] {
        CLS_R3, CLS_R2, CLS_MD, CLS_NOP, CLS_HALT, CLS_ILL
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_R3;
            OP_NEG, OP_NOT:                 return CLS_R2;
            OP_MUL, OP_DIV:                 return CLS_MD;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILL;
        endcase
    endfunction

    function automatic logic [4:0] alu_op_of(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index to one-hot select vector,
// all-zero when not enabled.
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the
// single-bus CPU datapath.
import cpu_ctrl_pkg::*;

module control_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             ZHighout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [4:0]       alu_op,
    output logic             stop,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [OPW-1:0]   opc_q, opc_d;
    logic [3:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    op_class_e        cls;
    logic             rin_en, rout_en;
    logic [3:0]       rin_idx, rout_idx;
    logic             unused_ir;

    assign unused_ir = ^ir[14:0];
    assign cls = op_class(opc_q);

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        unique case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1, S_T1W:
                state_d = mem_ready ? S_T2 : S_T1W;
            S_T2: begin
                // Fields are frozen here for the whole execute phase
                state_d = S_T3;
                opc_d   = ir[31 -: OPW];
                ra_d    = ir[26:23];
                rb_d    = ir[22:19];
                rc_d    = ir[18:15];
            end
            S_T3: begin
                case (cls)
                    CLS_R3, CLS_R2, CLS_MD: state_d = S_T4;
                    CLS_NOP:  state_d = Run ? S_T0 : S_IDLE;
                    CLS_HALT: state_d = S_HALTED;
                    default:  state_d = S_T0;
                endcase
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls == CLS_MD) state_d = S_T6;
                else               state_d = Run ? S_T0 : S_IDLE;
            end
            S_T6:     state_d = Run ? S_T0 : S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read} = '0;
        {IRin, Yin, Zin, Zlowout, ZHighout, HIin, LOin}  = '0;
        alu_op   = '0;
        stop     = 1'b0;
        illegal  = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_idx  = ra_q;
        rout_idx = '0;
        unique case (state_q)
            S_T0: {PCout, MARin, IncPC, Zin} = '1;
            S_T1: {Zlowout, PCin, Read, MDRin} = '1;
            S_T1W: {Read, MDRin} = '1;
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                case (cls)
                    CLS_R3: begin
                        rout_en  = 1'b1;
                        rout_idx = rb_q;
                        Yin      = 1'b1;
                    end
                    CLS_MD: begin
                        rout_en  = 1'b1;
                        rout_idx = ra_q;
                        Yin      = 1'b1;
                    end
                    CLS_ILL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                rout_en  = 1'b1;
                rout_idx = (cls == CLS_R3) ? rc_q : rb_q;
                alu_op   = alu_op_of(opc_q);
                Zin      = 1'b1;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_MD) LOin   = 1'b1;
                else               rin_en = 1'b1;
            end
            S_T6:     {ZHighout, HIin} = '1;
            S_HALTED: stop = 1'b1;
            default: ;
        endcase
    end

    reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
        .idx_i    (rin_idx),
        .en_i     (rin_en),
        .onehot_o (Rin)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, wait states,
// R3/MD/illegal/HALT/NOP flows, Clear and Run handling.
module tb_control_sequencer;

    logic        Clock, Clear, Run, mem_ready;
    logic [31:0] ir;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read;
    logic        IRin, Yin, Zin, Zlowout, ZHighout, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        stop, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe bit positions within the packed observation
    localparam logic [13:0] B_T0  = 14'h2C10;
    localparam logic [13:0] B_T1  = 14'h1288;
    localparam logic [13:0] B_T1W = 14'h0280;
    localparam logic [13:0] B_T2  = 14'h0140;
    localparam logic [13:0] B_YIN = 14'h0020;
    localparam logic [13:0] B_ZIN = 14'h0010;
    localparam logic [13:0] B_ZLO = 14'h0008;
    localparam logic [13:0] B_ZHI = 14'h0004;
    localparam logic [13:0] B_HI  = 14'h0002;
    localparam logic [13:0] B_LO  = 14'h0001;

    localparam logic [31:0] IR_OR   = 32'h4A920000;
    localparam logic [31:0] IR_MUL  = 32'h71B00000;
    localparam logic [31:0] IR_ILL  = 32'hF8000000;
    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;

    logic [63:0] obs;
    assign obs = {11'd0,
                  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read,
                  IRin, Yin, Zin, Zlowout, ZHighout, HIin, LOin,
                  Rin, Rout, alu_op, stop, illegal};

    control_sequencer #(.NREGS(16), .OPW(5)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run),
        .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .ZHighout(ZHighout),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .stop(stop), .illegal(illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [63:0] ex(
        input logic [13:0] s,
        input logic [15:0] ri,
        input logic [15:0] ro,
        input logic [4:0]  a,
        input logic        st,
        input logic        il
    );
        return {11'd0, s, ri, ro, a, st, il};
    endfunction

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic [63:0] want);
        @(negedge Clock);
        check(tag, obs, want);
    endtask

    logic [63:0] Z, T0, T1, T1W, T2, STP;

    initial begin
        Z   = ex(14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        T0  = ex(B_T0,  16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        T1  = ex(B_T1,  16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        T1W = ex(B_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        T2  = ex(B_T2,  16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        STP = ex(14'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

        Clear = 1'b1; Run = 1'b0; mem_ready = 1'b1; ir = '0;
        cyc("rst0", Z);
        cyc("rst1", Z);
        Clear = 1'b0;
        cyc("idle", Z);

        // OR R5,R2,R4 with zero-wait memory
        ir = IR_OR; Run = 1'b1;
        cyc("or_t0", T0);
        cyc("or_t1", T1);
        cyc("or_t2", T2);
        cyc("or_t3", ex(B_YIN, 16'h0, 16'h0004, 5'd0, 1'b0, 1'b0));
        cyc("or_t4", ex(B_ZIN, 16'h0, 16'h0010, 5'b01010, 1'b0, 1'b0));
        cyc("or_t5", ex(B_ZLO, 16'h0020, 16'h0, 5'd0, 1'b0, 1'b0));
        cyc("or2_t0", T0);

        // Same OR with three memory wait states
        mem_ready = 1'b0;
        cyc("or2_t1", T1);
        cyc("or2_w1", T1W);
        cyc("or2_w2", T1W);
        cyc("or2_w3", T1W);
        mem_ready = 1'b1;
        cyc("or2_t2", T2);
        cyc("or2_t3", ex(B_YIN, 16'h0, 16'h0004, 5'd0, 1'b0, 1'b0));
        cyc("or2_t4", ex(B_ZIN, 16'h0, 16'h0010, 5'b01010, 1'b0, 1'b0));
        cyc("or2_t5", ex(B_ZLO, 16'h0020, 16'h0, 5'd0, 1'b0, 1'b0));

        // MUL R3,R6; ir disturbed after latch; Run dropped in T4
        ir = IR_MUL;
        cyc("mul_t0", T0);
        cyc("mul_t1", T1);
        cyc("mul_t2", T2);
        cyc("mul_t3", ex(B_YIN, 16'h0, 16'h0008, 5'd0, 1'b0, 1'b0));
        ir = '0;
        cyc("mul_t4", ex(B_ZIN, 16'h0, 16'h0040, 5'b01110, 1'b0, 1'b0));
        Run = 1'b0;
        cyc("mul_t5", ex(B_ZLO | B_LO, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
        cyc("mul_t6", ex(B_ZHI | B_HI, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
        cyc("mul_idle0", Z);
        cyc("mul_idle1", Z);

        // Illegal opcode 11111
        ir = IR_ILL; Run = 1'b1;
        cyc("ill_t0", T0);
        cyc("ill_t1", T1);
        cyc("ill_t2", T2);
        cyc("ill_t3", ex(14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1));

        // ADD R1,R2,R3 cleared in T4
        ir = IR_ADD;
        cyc("ill_next_t0", T0);
        cyc("add_t1", T1);
        cyc("add_t2", T2);
        cyc("add_t3", ex(B_YIN, 16'h0, 16'h0004, 5'd0, 1'b0, 1'b0));
        cyc("add_t4", ex(B_ZIN, 16'h0, 16'h0008, 5'b00011, 1'b0, 1'b0));
        Clear = 1'b1;
        cyc("add_clr", Z);
        Clear = 1'b0;
        cyc("clr_t0", T0);

        // HALT holds against Run toggling until Clear
        ir = IR_HALT;
        cyc("halt_t1", T1);
        cyc("halt_t2", T2);
        cyc("halt_t3", Z);
        cyc("halt_stop", STP);
        for (int i = 0; i < 4; i++) begin
            Run = ~Run;
            cyc("halt_hold", STP);
        end
        Clear = 1'b1;
        cyc("halt_clr", Z);

        // NOP with Run dropped at instruction end
        Clear = 1'b0; Run = 1'b1; ir = IR_NOP;
        cyc("nop_t0", T0);
        cyc("nop_t1", T1);
        cyc("nop_t2", T2);
        cyc("nop_t3", Z);
        Run = 1'b0;
        cyc("nop_idle", Z);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
